lcd_scanout: RTL and testbench

Display-side reader of the screen VRAM buffer. The screen fetcher writes the 640×64 Z88 bitmap into a 16K×4 dual-port VRAM; this block reads it back as 4-pixel nibbles. It serialises the nibbles into a 1-bit pixel stream with data-enable, horizontal sync and vertical sync for the LCD/video output stage. It owns all raster timing and never writes VRAM.

---
 rtl/lcd_scanout.sv | 185 ++++++++++++++++++
 tb/tb_lcd_scanout.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scanout.sv
// Raster timing generator and VRAM scan-out: reads 4-pixel nibbles and serialises them into a
// 1-bit pixel stream with data-enable, horizontal and vertical sync.
module lcd_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 64,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 4,
  parameter int unsigned PIX_DIV  = 1
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        lcdon,
  output logic [13:0] vram_ra,
  output logic        vram_re,
  input  logic [3:0]  vram_di,
  output logic        pix,
  output logic        de,
  output logic        hs,
  output logic        vs,
  output logic        sof
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [13:0]   LINE_WORDS = 14'(H_ACTIVE / 4);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [13:0]   lbase_q, lbase_d;
  logic [13:0]   ra_q, ra_d;
  logic          re_q, re_d;
  logic          fon_q, fon_d;
  logic [3:0]    hold_q, hold_d;
  logic [3:0]    shreg_q, shreg_d;

  // Stage 1 carries stage-0 decodes; stage 2 drives the outputs.
  logic rd1_q, rd1_d, de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, sof1_q, sof1_d, on1_q, on1_d;
  logic de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d, sof2_q, sof2_d, on2_q, on2_d;

  logic pen, h_wrap, v_wrap, active, frame_start, fon_cur, issue, hs_dec, vs_dec;

  always_comb begin
    pen         = (div_q == DIV_LAST);
    h_wrap      = (hcnt_q == H_LAST);
    v_wrap      = (vcnt_q == V_LAST);
    active      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    // The first pixel of a frame already obeys the lcdon value being sampled on this tick.
    fon_cur     = frame_start ? lcdon : fon_q;
    issue       = pen && active && (hcnt_q[1:0] == 2'b00) && fon_cur;
    hs_dec      = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
    vs_dec      = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  end

  always_comb begin
    div_d   = div_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    lbase_d = lbase_q;
    fon_d   = fon_q;
    shreg_d = shreg_q;
    rd1_d   = rd1_q;
    de1_d   = de1_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    sof1_d  = sof1_q;
    on1_d   = on1_q;
    de2_d   = de2_q;
    hs2_d   = hs2_q;
    vs2_d   = vs2_q;
    sof2_d  = sof2_q;
    on2_d   = on2_q;

    re_d   = issue;
    ra_d   = issue ? (lbase_q + 14'(hcnt_q >> 2)) : ra_q;
    // Read data is only guaranteed on the edge after the strobe, which precedes the next pen
    // when PIX_DIV > 1.
    hold_d = re_q ? vram_di : hold_q;

    if (pen) begin
      div_d  = '0;
      hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
      if (h_wrap) begin
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
        if (v_wrap) begin
          lbase_d = '0;
        end else if (vcnt_q < V_ACT) begin
          lbase_d = lbase_q + LINE_WORDS;
        end
      end
      if (frame_start) begin
        fon_d = lcdon;
      end

      rd1_d  = issue;
      de1_d  = active;
      hs1_d  = hs_dec;
      vs1_d  = vs_dec;
      sof1_d = frame_start && fon_cur;
      on1_d  = fon_cur;

      shreg_d = rd1_q ? (re_q ? vram_di : hold_q) : {shreg_q[2:0], 1'b0};
      de2_d   = de1_q;
      hs2_d   = hs1_q;
      vs2_d   = vs1_q;
      sof2_d  = sof1_q;
      on2_d   = on1_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      lbase_q <= '0;
      ra_q    <= '0;
      re_q    <= 1'b0;
      fon_q   <= 1'b0;
      hold_q  <= '0;
      shreg_q <= '0;
      rd1_q   <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      sof1_q  <= 1'b0;
      on1_q   <= 1'b0;
      de2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      sof2_q  <= 1'b0;
      on2_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      lbase_q <= lbase_d;
      ra_q    <= ra_d;
      re_q    <= re_d;
      fon_q   <= fon_d;
      hold_q  <= hold_d;
      shreg_q <= shreg_d;
      rd1_q   <= rd1_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      sof1_q  <= sof1_d;
      on1_q   <= on1_d;
      de2_q   <= de2_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      sof2_q  <= sof2_d;
      on2_q   <= on2_d;
    end
  end

  assign vram_ra = ra_q;
  assign vram_re = re_q;
  assign pix     = shreg_q[3] & de2_q & on2_q;
  assign de      = de2_q;
  assign hs      = hs2_q;
  assign vs      = vs2_q;
  assign sof     = sof2_q & pen;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: full-size raster at PIX_DIV=1 plus a reduced raster at PIX_DIV=3 for
// lcdon gating and mid-frame reset. VRAM model returns nibble = address[3:0].
module tb_lcd_scanout;

  logic mck = 1'b0;
  always #5 mck = ~mck;

  int checks = 0;
  int errors = 0;

  logic        rst_a_n, lcdon_a, re_a, pix_a, de_a, hs_a, vs_a, sof_a;
  logic [13:0] ra_a;
  logic [3:0]  di_a;
  logic        rst_b_n, lcdon_b, re_b, pix_b, de_b, hs_b, vs_b, sof_b;
  logic [13:0] ra_b;
  logic [3:0]  di_b;

  assign di_a = ra_a[3:0];
  assign di_b = ra_b[3:0];

  lcd_scanout dut_a (
    .mck(mck), .rin_n(rst_a_n), .lcdon(lcdon_a), .vram_ra(ra_a), .vram_re(re_a),
    .vram_di(di_a), .pix(pix_a), .de(de_a), .hs(hs_a), .vs(vs_a), .sof(sof_a)
  );

  // Reduced raster: H_TOTAL 24, V_TOTAL 8, frame = 192 pen = 576 mck.
  lcd_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(3)
  ) dut_b (
    .mck(mck), .rin_n(rst_b_n), .lcdon(lcdon_b), .vram_ra(ra_b), .vram_re(re_b),
    .vram_di(di_b), .pix(pix_b), .de(de_b), .hs(hs_b), .vs(vs_b), .sof(sof_b)
  );

  int addr_q[$];
  bit pix_q[$];
  int sb;

  task automatic push_pixels(input int ea);
    for (int b = 3; b >= 0; b--) pix_q.push_back(((ea >> b) & 1) != 0);
  endtask

  task automatic test_reset();
    lcdon_a = 1'b1;
    lcdon_b = 1'b1;
    repeat (5) @(negedge mck);
    checks++;
    if ({ra_a, re_a, pix_a, de_a, hs_a, vs_a, sof_a} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs_a: got %h required 0",
               {ra_a, re_a, pix_a, de_a, hs_a, vs_a, sof_a});
    end
    checks++;
    if ({ra_b, re_b, pix_b, de_b, hs_b, vs_b, sof_b} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %h required 0",
               {ra_b, re_b, pix_b, de_b, hs_b, vs_b, sof_b});
    end
    rst_a_n = 1'b1;
  endtask

  // Sample s follows posedge s after release; read for position n seen at s=n, output at s=n+1.
  task automatic test_frame();
    int h, v, m, ea, first_re, first_de, hs_start, hs_len, vs_start, vs_len;
    int sof_s[$];
    bit e_de, e_hs, e_vs, e_sof, e_re, ep;
    logic [4:0] exp_v;
    addr_q.delete();
    pix_q.delete();
    for (int l = 0; l < 64; l++)
      for (int k = 0; k < 160; k++) addr_q.push_back(l * 160 + k);
    addr_q.push_back(0);
    first_re = -1; first_de = -1; hs_start = -1; hs_len = 0; vs_start = -1; vs_len = 0;
    for (int s = 0; s <= 57602; s++) begin
      @(negedge mck);
      h = s % 800;
      v = (s / 800) % 72;
      e_re = (h < 640) && (v < 64) && (h % 4 == 0);
      e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_sof = 1'b0;
      if (s >= 1) begin
        m = s - 1;
        h = m % 800;
        v = (m / 800) % 72;
        e_de  = (h < 640) && (v < 64);
        e_hs  = (h >= 656) && (h < 752);
        e_vs  = (v >= 66) && (v < 68);
        e_sof = (m % 57600 == 0);
      end
      exp_v = {e_re, e_de, e_hs, e_vs, e_sof};
      checks++;
      if ({re_a, de_a, hs_a, vs_a, sof_a} !== exp_v) begin
        errors++;
        $display("FAIL raster_a s=%0d: got re,de,hs,vs,sof=%b required %b", s,
                 {re_a, de_a, hs_a, vs_a, sof_a}, exp_v);
      end
      if (re_a === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL read_addr_a s=%0d: got read at %0d required no read", s, ra_a);
        end else begin
          ea = addr_q.pop_front();
          if (ra_a !== 14'(ea)) begin
            errors++;
            $display("FAIL read_addr_a s=%0d: got %0d required %0d", s, ra_a, ea);
          end
          push_pixels(ea);
        end
      end
      checks++;
      if (de_a === 1'b1) begin
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL pix_a s=%0d: got pixel %b required no pending pixel", s, pix_a);
        end else begin
          ep = pix_q.pop_front();
          if (pix_a !== ep) begin
            errors++;
            $display("FAIL pix_a s=%0d: got %b required %b", s, pix_a, ep);
          end
        end
      end else if (pix_a !== 1'b0) begin
        errors++;
        $display("FAIL pix_blank_a s=%0d: got %b required 0", s, pix_a);
      end
      if (s == 800) begin
        checks++;
        if (re_a !== 1'b1 || ra_a !== 14'd160) begin
          errors++;
          $display("FAIL line1_first_read: got re=%b ra=%0d required re=1 ra=160", re_a, ra_a);
        end
      end
      if (s == 51036) begin
        checks++;
        if (re_a !== 1'b1 || ra_a !== 14'd10239) begin
          errors++;
          $display("FAIL last_read: got re=%b ra=%0d required re=1 ra=10239", re_a, ra_a);
        end
      end
      if (re_a === 1'b1 && first_re < 0) first_re = s;
      if (de_a === 1'b1 && first_de < 0) first_de = s;
      if (hs_a === 1'b1 && s <= 800) begin
        hs_len++;
        if (hs_start < 0) hs_start = s - 1;
      end
      if (vs_a === 1'b1 && s <= 57600) begin
        vs_len++;
        if (vs_start < 0) vs_start = s - 1;
      end
      if (sof_a === 1'b1) sof_s.push_back(s);
    end
    checks++;
    if (first_re != 0) begin
      errors++;
      $display("FAIL first_re_cycle: got %0d required 0", first_re);
    end
    checks++;
    if (first_de != 1) begin
      errors++;
      $display("FAIL first_de_cycle: got %0d required 1", first_de);
    end
    checks++;
    if (hs_start != 656 || hs_len != 96) begin
      errors++;
      $display("FAIL hs_pulse: got start=%0d len=%0d required 656 96", hs_start, hs_len);
    end
    checks++;
    if (vs_start != 66 * 800 || vs_len != 1600) begin
      errors++;
      $display("FAIL vs_pulse: got start=%0d len=%0d required 52800 1600", vs_start, vs_len);
    end
    checks++;
    if (sof_s.size() != 2 || sof_s[1] - sof_s[0] != 57600) begin
      errors++;
      $display("FAIL frame_period: got %0d sof pulses required 2 spaced 57600", sof_s.size());
    end
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL read_count_a: got %0d reads missing required 0", addr_q.size());
    end
  endtask

  // PIX_DIV=3: pen edges at s=3n+2; read for n seen at s=3n+2; output n held at s in [3n+5,3n+8).
  task automatic test_pix_div();
    int n, h, v, ea;
    bit e_re, e_de, e_hs, e_vs, e_sof, cur;
    logic [4:0] exp_v;
    addr_q.delete();
    pix_q.delete();
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 4; k++) addr_q.push_back(l * 4 + k);
    cur = 1'b0;
    lcdon_b = 1'b1;
    rst_b_n = 1'b1;
    for (sb = 0; sb <= 575; sb++) begin
      @(negedge mck);
      e_re = 1'b0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_sof = 1'b0;
      if (sb >= 2 && (sb - 2) % 3 == 0) begin
        n = (sb - 2) / 3;
        h = n % 24;
        v = (n / 24) % 8;
        e_re = (h < 16) && (v < 4) && (h % 4 == 0);
      end
      if (sb >= 5) begin
        n = (sb - 5) / 3;
        h = n % 24;
        v = (n / 24) % 8;
        e_de  = (h < 16) && (v < 4);
        e_hs  = (h >= 18) && (h < 22);
        e_vs  = (v >= 5) && (v < 7);
        e_sof = (n % 192 == 0) && (sb % 3 == 1);
      end
      exp_v = {e_re, e_de, e_hs, e_vs, e_sof};
      checks++;
      if ({re_b, de_b, hs_b, vs_b, sof_b} !== exp_v) begin
        errors++;
        $display("FAIL raster_b s=%0d: got re,de,hs,vs,sof=%b required %b", sb,
                 {re_b, de_b, hs_b, vs_b, sof_b}, exp_v);
      end
      if (re_b === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL read_addr_b s=%0d: got read at %0d required no read", sb, ra_b);
        end else begin
          ea = addr_q.pop_front();
          if (ra_b !== 14'(ea)) begin
            errors++;
            $display("FAIL read_addr_b s=%0d: got %0d required %0d", sb, ra_b, ea);
          end
          push_pixels(ea);
        end
      end
      checks++;
      if (de_b === 1'b1) begin
        if (sb >= 5 && (sb - 5) % 3 == 0) begin
          if (pix_q.size() == 0) cur = 1'bx;
          else cur = pix_q.pop_front();
        end
        if (pix_b !== cur) begin
          errors++;
          $display("FAIL pix_b s=%0d: got %b required %b", sb, pix_b, cur);
        end
      end else if (pix_b !== 1'b0) begin
        errors++;
        $display("FAIL pix_blank_b s=%0d: got %b required 0", sb, pix_b);
      end
    end
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL read_count_b: got %0d reads missing required 0", addr_q.size());
    end
  endtask

  // lcdon drops mid frame 1, rises mid frame 2: frames 1 and 3 scan out, frame 2 is dark.
  task automatic test_lcdon();
    int rd_cnt[4], sof_cnt[4], de_cnt[4], hs_cnt[4], vs_cnt[4], one_cnt[4];
    int fo, fr, exp_ones;
    bit on;
    logic [3:0] nib;
    exp_ones = 0;
    for (int a = 0; a < 16; a++) begin
      nib = a[3:0];
      exp_ones += 3 * $countones(nib);
    end
    for (int f = 0; f < 4; f++) begin
      rd_cnt[f] = 0; sof_cnt[f] = 0; de_cnt[f] = 0; hs_cnt[f] = 0; vs_cnt[f] = 0; one_cnt[f] = 0;
    end
    for (sb = 576; sb <= 2309; sb++) begin
      @(negedge mck);
      fr = (sb - 2) / 576;
      fo = (sb - 5) / 576;
      if (re_b === 1'b1 && fr < 4) rd_cnt[fr]++;
      if (fo < 4) begin
        if (sof_b === 1'b1) sof_cnt[fo]++;
        if (de_b === 1'b1) de_cnt[fo]++;
        if (hs_b === 1'b1) hs_cnt[fo]++;
        if (vs_b === 1'b1) vs_cnt[fo]++;
        if (pix_b === 1'b1) one_cnt[fo]++;
      end
      if (sb == 722) lcdon_b = 1'b0;
      if (sb == 1300) lcdon_b = 1'b1;
    end
    for (int f = 1; f < 4; f++) begin
      on = (f != 2);
      checks++;
      if (rd_cnt[f] != (on ? 16 : 0)) begin
        errors++;
        $display("FAIL lcdon_reads f=%0d: got %0d required %0d", f, rd_cnt[f], on ? 16 : 0);
      end
      checks++;
      if (sof_cnt[f] != (on ? 1 : 0)) begin
        errors++;
        $display("FAIL lcdon_sof f=%0d: got %0d required %0d", f, sof_cnt[f], on ? 1 : 0);
      end
      checks++;
      if (one_cnt[f] != (on ? exp_ones : 0)) begin
        errors++;
        $display("FAIL lcdon_pix f=%0d: got %0d required %0d", f, one_cnt[f],
                 on ? exp_ones : 0);
      end
      checks++;
      if (de_cnt[f] != 192) begin
        errors++;
        $display("FAIL lcdon_de f=%0d: got %0d required 192", f, de_cnt[f]);
      end
      checks++;
      if (hs_cnt[f] != 96) begin
        errors++;
        $display("FAIL lcdon_hs f=%0d: got %0d required 96", f, hs_cnt[f]);
      end
      checks++;
      if (vs_cnt[f] != 144) begin
        errors++;
        $display("FAIL lcdon_vs f=%0d: got %0d required 144", f, vs_cnt[f]);
      end
    end
  endtask

  // Reset pulse at frame 4, line 2, pixel 9; raster and read addresses restart from zero.
  task automatic test_mid_reset();
    int n, h, ea;
    bit e_re, e_de;
    for (sb = 2310; sb <= 2477; sb++) @(negedge mck);
    checks++;
    if (de_b !== 1'b1 || ra_b !== 14'd10) begin
      errors++;
      $display("FAIL pre_reset_state: got de=%b ra=%0d required de=1 ra=10", de_b, ra_b);
    end
    #1 rst_b_n = 1'b0;
    #1;
    checks++;
    if ({ra_b, re_b, pix_b, de_b, hs_b, vs_b, sof_b} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h required 0",
               {ra_b, re_b, pix_b, de_b, hs_b, vs_b, sof_b});
    end
    @(negedge mck);
    rst_b_n = 1'b1;
    addr_q.delete();
    for (int k = 0; k < 4; k++) addr_q.push_back(k);
    for (int s = 0; s <= 40; s++) begin
      @(negedge mck);
      e_re = 1'b0;
      if (s >= 2 && (s - 2) % 3 == 0) begin
        n = (s - 2) / 3;
        h = n % 24;
        e_re = (h < 16) && (h % 4 == 0);
      end
      e_de = (s >= 5);
      checks++;
      if ({re_b, de_b} !== {e_re, e_de}) begin
        errors++;
        $display("FAIL restart_raster s=%0d: got re,de=%b required %b", s, {re_b, de_b},
                 {e_re, e_de});
      end
      if (re_b === 1'b1) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL restart_addr s=%0d: got read at %0d required no read", s, ra_b);
        end else begin
          ea = addr_q.pop_front();
          if (ra_b !== 14'(ea)) begin
            errors++;
            $display("FAIL restart_addr s=%0d: got %0d required %0d", s, ra_b, ea);
          end
        end
      end
    end
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL restart_read_count: got %0d reads missing required 0", addr_q.size());
    end
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    lcdon_a = 1'b0;
    lcdon_b = 1'b0;
    sb = 0;
    test_reset();
    test_frame();
    test_pix_div();
    test_lcdon();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
